systolic_output_deskew: RTL and testbench

// - Downstream stage of the systolic array. Consumes the COL south-edge result lanes.
// - Lane j of result row r arrives j cycles after lane 0.
// - Re-aligns lanes into whole rows and buffers them in a FIFO.
// - Writes rows sequentially into output buffer memory under a valid/ready handshake.
// - Array cannot stall, so FIFO overflow is flagged, never back-pressured.

---
 rtl/ob_deskew_pkg.sv | 20 ++
 rtl/sync_row_fifo.sv | 52 +++++
 rtl/systolic_output_deskew.sv | 156 +++++++++++++++
 tb/tb_systolic_output_deskew.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ob_deskew_pkg.sv
// Shared types and default sizes for the systolic output deskew stage.
package ob_deskew_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned COL_DEF    = 4;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // One aligned result row, lane j in element j.
  typedef logic [COL_DEF-1:0][WIDTH_DEF-1:0] row_t;

endpackage

// File: rtl/sync_row_fifo.sv
// Single-clock row FIFO with combinational head data.
module sync_row_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage array; contents need no reset since reads are qualified by count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns skewed south-edge result lanes into rows and streams them to the output buffer.
module systolic_output_deskew
  import ob_deskew_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned COL    = COL_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       n_rows_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic                   result_valid_i,
  input  logic [COL*WIDTH-1:0]   pe_result_i,
  output logic                   ob_wr_en_o,
  input  logic                   ob_ready_i,
  output logic [ADDR_W-1:0]      ob_wr_addr_o,
  output logic [COL*WIDTH-1:0]   ob_wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  localparam int unsigned RW     = COL * WIDTH;
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_rows_q, rows_acc_q, written_q, dropped_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                overflow_q;
  logic [COL-2:0]      vld_pipe_q;
  logic [RW-1:0]       aligned_row;
  logic                vld_in, aligned_vld;
  logic                fifo_full, fifo_empty, push, pop, drop, start_ok;
  logic [FCNT_W-1:0]   fifo_count;
  logic [RW-1:0]       fifo_head;
  logic                is_busy;
  logic                all_rows_settled;

  // Only pulses accepted while collecting enter the valid pipe.
  assign vld_in   = result_valid_i && (state_q == COLLECT);
  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign is_busy  = (state_q == COLLECT) || (state_q == DRAIN);

  // Per-lane delay chains: lane j waits COL-1-j cycles for the last lane to arrive.
  for (genvar j = 0; j < COL - 1; j++) begin : g_lane
    localparam int unsigned D = COL - 1 - j;
    logic [WIDTH-1:0] chain_q [D];

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int k = 0; k < D; k++) chain_q[k] <= '0;
      end else begin
        chain_q[0] <= pe_result_i[j*WIDTH +: WIDTH];
        for (int k = 1; k < D; k++) chain_q[k] <= chain_q[k-1];
      end
    end

    assign aligned_row[j*WIDTH +: WIDTH] = chain_q[D-1];
  end
  assign aligned_row[(COL-1)*WIDTH +: WIDTH] = pe_result_i[(COL-1)*WIDTH +: WIDTH];

  // Row-valid delay matching the lane-0 chain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= vld_in;
      for (int k = 1; k < COL - 1; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end
  assign aligned_vld = vld_pipe_q[COL-2];

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign pop  = ob_wr_en_o && ob_ready_i;
  assign push = aligned_vld && (!fifo_full || pop);
  assign drop = aligned_vld && fifo_full && !pop;

  sync_row_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_data_i (aligned_row),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign all_rows_settled =
    ((CNT_W+1)'(written_q) + (CNT_W+1)'(dropped_q)) == (CNT_W+1)'(n_rows_q);

  // Job state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = COLLECT;
      COLLECT:    if (result_valid_i && (CNT_W'(rows_acc_q + CNT_W'(1)) == n_rows_q))
                    state_d = DRAIN;
      DRAIN:      if ((vld_pipe_q == '0) && (fifo_count == '0) && all_rows_settled)
                    state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Job configuration, progress counters, write address and sticky overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      n_rows_q   <= '0;
      rows_acc_q <= '0;
      written_q  <= '0;
      dropped_q  <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else if (start_ok) begin
      n_rows_q   <= (n_rows_i == '0) ? CNT_W'(1) : n_rows_i;
      rows_acc_q <= '0;
      written_q  <= '0;
      dropped_q  <= '0;
      addr_q     <= base_addr_i;
      overflow_q <= 1'b0;
    end else begin
      if (vld_in) rows_acc_q <= rows_acc_q + CNT_W'(1);
      if (pop) begin
        written_q <= written_q + CNT_W'(1);
        addr_q    <= addr_q + ADDR_W'(1);
      end
      if (drop) begin
        dropped_q  <= dropped_q + CNT_W'(1);
        overflow_q <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; data is zeroed when no request is pending.
  assign ob_wr_en_o   = !fifo_empty && is_busy;
  assign ob_wr_addr_o = addr_q;
  assign ob_wr_data_o = ob_wr_en_o ? fifo_head : '0;
  assign busy_o       = is_busy;
  assign done_o       = (state_q == DONE);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew: skewed row feeds, stalls, overflow, wrap, reset.
module tb_systolic_output_deskew;
  import ob_deskew_pkg::*;

  logic                              clk_i = 1'b0;
  logic                              rstn_i;
  logic                              start_i;
  logic [CNT_W_DEF-1:0]              n_rows_i;
  logic [ADDR_W_DEF-1:0]             base_addr_i;
  logic                              result_valid_i;
  logic [COL_DEF*WIDTH_DEF-1:0]      pe_result_i;
  logic                              ob_wr_en_o;
  logic                              ob_ready_i;
  logic [ADDR_W_DEF-1:0]             ob_wr_addr_o;
  logic [COL_DEF*WIDTH_DEF-1:0]      ob_wr_data_o;
  logic                              busy_o;
  logic                              done_o;
  logic                              overflow_o;

  systolic_output_deskew dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (start_i),
    .n_rows_i       (n_rows_i),
    .base_addr_i    (base_addr_i),
    .result_valid_i (result_valid_i),
    .pe_result_i    (pe_result_i),
    .ob_wr_en_o     (ob_wr_en_o),
    .ob_ready_i     (ob_ready_i),
    .ob_wr_addr_o   (ob_wr_addr_o),
    .ob_wr_data_o   (ob_wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int feed_t0 = -1000;
  int feed_n = 0;
  int ready_from = 0;
  logic [7:0] job_base = 8'h00;
  int exp_n = 0;
  int wr_idx = 0;
  int first_hs = -1;
  int last_hs = -1;

  // Expected aligned row r: lane j holds r*16+j.
  function automatic logic [31:0] row_val(input int r);
    row_t v;
    for (int j = 0; j < COL_DEF; j++) v[j] = 8'(r * 16 + j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Skewed lane feed: lane j of row r appears at cycle feed_t0 + r + j.
  task automatic drive_lanes();
    int rel;
    int r;
    rel = cyc - feed_t0;
    result_valid_i = (rel >= 0) && (rel < feed_n);
    for (int j = 0; j < COL_DEF; j++) begin
      r = rel - j;
      pe_result_i[j*WIDTH_DEF +: WIDTH_DEF] = ((r >= 0) && (r < feed_n)) ? 8'(r * 16 + j) : 8'hEE;
    end
    ob_ready_i = (cyc >= ready_from);
  endtask

  // Advance one cycle, drive inputs, and check any pending write against the expected row.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    drive_lanes();
    if (ob_wr_en_o === 1'b1) begin
      chk("wr_in_range", 32'(wr_idx < exp_n), 32'd1);
      chk("wr_addr", 32'(ob_wr_addr_o), 32'(8'(job_base + 8'(wr_idx))));
      chk("wr_data", ob_wr_data_o, row_val(wr_idx));
      if (ob_ready_i) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        wr_idx++;
      end
    end
  endtask

  task automatic start_job(input int n_cfg, input logic [7:0] base, input int n_feed,
                           input int exp_writes, input int ready_delay);
    start_i     = 1'b1;
    n_rows_i    = 8'(n_cfg);
    base_addr_i = base;
    job_base    = base;
    exp_n       = exp_writes;
    wr_idx      = 0;
    first_hs    = -1;
    last_hs     = -1;
    feed_t0     = cyc + 1;
    feed_n      = n_feed;
    ready_from  = cyc + 1 + ready_delay;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && done_o !== 1'b1; k++) tick();
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  initial begin
    rstn_i = 1'b0;
    start_i = 1'b0;
    n_rows_i = '0;
    base_addr_i = '0;
    result_valid_i = 1'b0;
    pe_result_i = '0;
    ob_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wr_en", 32'(ob_wr_en_o), 32'd0);
    chk("rst_addr", 32'(ob_wr_addr_o), 32'd0);
    chk("rst_data", ob_wr_data_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    rstn_i = 1'b1;

    // Valid pulses while idle produce no writes
    exp_n = 0; wr_idx = 0; feed_t0 = cyc + 1; feed_n = 2; ready_from = 0;
    repeat (10) tick();
    chk("idle_writes", 32'(wr_idx), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Basic job: 4 rows at 0x10, ready always high
    start_job(4, 8'h10, 4, 4, 0);
    chk("a_busy", 32'(busy_o), 32'd1);
    wait_done(60);
    chk("a_writes", 32'(wr_idx), 32'd4);
    chk("a_latency", 32'(first_hs - feed_t0), 32'd4);
    chk("a_overflow", 32'(overflow_o), 32'd0);

    // 8 rows into an 8-deep FIFO with a 20-cycle stall
    start_job(8, 8'h20, 8, 8, 20);
    wait_done(100);
    chk("b_writes", 32'(wr_idx), 32'd8);
    chk("b_overflow", 32'(overflow_o), 32'd0);
    chk("b_first_after_stall", 32'(first_hs - ready_from), 32'd0);
    chk("b_rate", 32'(last_hs - first_hs), 32'd7);

    // 10 rows with the sink stalled: last two dropped
    start_job(10, 8'h30, 10, 8, 30);
    wait_done(100);
    chk("c_writes", 32'(wr_idx), 32'd8);
    chk("c_overflow", 32'(overflow_o), 32'd1);

    // Address wrap 0xFE -> 0x00, with an ignored start during collection
    start_job(3, 8'hFE, 3, 3, 0);
    start_i = 1'b1; n_rows_i = 8'd1; base_addr_i = 8'h99;
    tick();
    start_i = 1'b0;
    chk("d_busy_after_start", 32'(busy_o), 32'd1);
    wait_done(60);
    chk("d_writes", 32'(wr_idx), 32'd3);
    chk("d_overflow_cleared", 32'(overflow_o), 32'd0);

    // n_rows = 0 is treated as one row; later pulses ignored
    start_job(0, 8'h50, 3, 1, 0);
    wait_done(60);
    repeat (8) tick();
    chk("e_writes", 32'(wr_idx), 32'd1);
    chk("e_done_hold", 32'(done_o), 32'd1);

    // Reset during DRAIN with 3 rows buffered
    start_job(3, 8'h60, 3, 3, 1000);
    repeat (6) tick();
    chk("f_busy", 32'(busy_o), 32'd1);
    chk("f_wr_en", 32'(ob_wr_en_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("f_rst_wr_en", 32'(ob_wr_en_o), 32'd0);
    chk("f_rst_busy", 32'(busy_o), 32'd0);
    chk("f_rst_data", ob_wr_data_o, 32'd0);
    chk("f_rst_addr", 32'(ob_wr_addr_o), 32'd0);
    chk("f_rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    start_job(2, 8'h70, 2, 2, 0);
    wait_done(60);
    chk("f_fresh_writes", 32'(wr_idx), 32'd2);
    chk("f_fresh_overflow", 32'(overflow_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
